// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin share of one registered-read ROM port among NUM_REQ requesters.
// Grants the address in the same cycle and returns the ROM word tagged to the winner one cycle later.
module rom_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]         ptr, inflight_id, win, nxt;
    logic                  inflight, any;
    logic [ADDR_WIDTH-1:0] last_addr;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NUM_REQ);
    endfunction

    assign any = |req;

    // Scan from the farthest offset down so the one closest to ptr wins.
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[wrap(int'(ptr) + k)]) win = wrap(int'(ptr) + k);
    end

    assign nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        gnt = '0;
        if (any && reset_n) gnt[win] = 1'b1;
    end

    always_comb begin
        rvalid = '0;
        rvalid[inflight_id] = inflight;
    end

    // Idle cycles replay the previous address so the ROM input stays quiet.
    assign rom_addr = !reset_n ? '0 : any ? addr[win*ADDR_WIDTH +: ADDR_WIDTH] : last_addr;
    assign rdata    = rom_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            inflight    <= 1'b0;
            inflight_id <= '0;
            last_addr   <= '0;
        end else begin
            last_addr <= rom_addr;
            inflight  <= any;
            if (any) begin
                ptr         <= nxt;
                inflight_id <= win;
            end
        end
    end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: directed literal checks plus randomized traffic against a
// round-robin reference model, with a ROM holding data = addr[1:0] ^ 2'b01.
module tb_rom_read_arbiter;
    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]  gnt, rvalid;
    logic [1:0]    rdata;
    logic [AW-1:0] rom_addr;
    logic [1:0]    rom_data = 2'b00;

    int n_cmp = 0;
    int n_fail = 0;

    // model state
    int          m_ptr = 0;
    bit          m_pv = 0;
    int          m_pid = 0;
    logic [1:0]  m_pd = '0;
    logic [AW-1:0] m_last = '0;
    logic [N-1:0] m_gnt = '0;
    int          waitc [N];

    rom_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[1:0] ^ 2'b01;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan from ptr with wraparound, one outstanding read per grant.
    initial begin
        int w;
        bit found;
        logic [AW-1:0] a;
        logic [N-1:0] eg;
        foreach (waitc[i]) waitc[i] = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_gnt", gnt, 0);
                chk("rst_rvalid", rvalid, 0);
                chk("rst_rom_addr", rom_addr, 0);
                m_ptr = 0; m_pv = 0; m_last = '0; m_gnt = '0;
                foreach (waitc[i]) waitc[i] = 0;
            end else begin
                chk("rvalid", rvalid, m_pv ? (32'd1 << m_pid) : 32'd0);
                if (m_pv) chk("rdata", rdata, m_pd);
                found = 0; w = 0;
                for (int k = 0; k < N; k++)
                    if (!found && ((req >> ((m_ptr + k) % N)) & 4'd1) != 0) begin
                        found = 1;
                        w = (m_ptr + k) % N;
                    end
                a = found ? AW'(addr >> (w * AW)) : m_last;
                eg = found ? N'(1 << w) : '0;
                chk("gnt", gnt, eg);
                chk("rom_addr", rom_addr, a);
                for (int i = 0; i < N; i++) begin
                    waitc[i] = (req[i] && !gnt[i]) ? waitc[i] + 1 : 0;
                    if (req[i]) chk("fair_wait_lt_n", waitc[i] < N, 1);
                end
                m_last = a;
                m_gnt = eg;
                m_pv = found;
                if (found) begin
                    m_ptr = (w + 1) % N;
                    m_pid = w;
                    m_pd = a[1:0] ^ 2'b01;
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic [N*AW-1:0] a);
        @(posedge clk);
        #1;
        req = r;
        addr = a;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        req = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_d [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rom_addr", rom_addr, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // single request
        cyc(4'b0001, 12'd5);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_rom_addr", rom_addr, 5);
        cyc(4'b0000, 12'd5);
        chk("t1_rvalid", rvalid, 4'b0001);
        chk("t1_rdata", rdata, 2'b00);
        chk("t1_idle_gnt", gnt, 0);
        cyc(4'b0000, 12'd5);
        chk("t1_rvalid_off", rvalid, 0);

        // full contention
        do_reset();
        for (int c = 0; c < 5; c++) begin
            cyc(4'b1111, 12'o3210);
            chk("t2_gnt", gnt, 32'd1 << (c % 4));
            if (c > 0) begin
                chk("t2_rvalid", rvalid, 32'd1 << ((c - 1) % 4));
                chk("t2_rdata", rdata, exp_d[(c - 1) % 4]);
            end
        end

        // rotation skipping an idle requester
        cyc(4'b0010, 12'o3210);
        chk("t3_gnt_r1", gnt, 4'b0010);
        cyc(4'b1011, 12'o3210);
        chk("t3_gnt_r3", gnt, 4'b1000);
        cyc(4'b1011, 12'o3210);
        chk("t3_gnt_r0", gnt, 4'b0001);
        cyc(4'b1011, 12'o3210);
        chk("t3_gnt_r1b", gnt, 4'b0010);

        // streaming from one requester
        for (int c = 0; c < 8; c++) begin
            cyc(4'b0001, 12'(c));
            chk("t4_gnt", gnt, 4'b0001);
            if (c > 0) begin
                chk("t4_rvalid", rvalid, 4'b0001);
                chk("t4_rdata", rdata, 2'((c - 1) & 3) ^ 2'b01);
            end
        end
        cyc(4'b0000, 12'd7);
        chk("t4_last_rvalid", rvalid, 4'b0001);
        chk("t4_last_rdata", rdata, 2'b10);

        // reset while a read is outstanding
        cyc(4'b0100, 12'o5000);
        chk("t5_gnt", gnt, 4'b0100);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_rvalid", rvalid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t5_no_stale", rvalid, 0);
        cyc(4'b1111, 12'o3210);
        chk("t5_restart_gnt", gnt, 4'b0001);

        // idle hold of the ROM address
        cyc(4'b0001, 12'd6);
        chk("t6_gnt", gnt, 4'b0001);
        for (int c = 0; c < 4; c++) begin
            cyc(4'b0000, 12'd0);
            chk("t6_rom_addr", rom_addr, 6);
            chk("t6_gnt", gnt, 0);
            chk("t6_rvalid", rvalid, c == 0 ? 4'b0001 : 4'b0000);
        end

        // randomized traffic: requesters hold req/addr until granted
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (!req[i] || m_gnt[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    addr[i*AW +: AW] = AW'($urandom);
                end
        end
        @(posedge clk);
        #1 req = '0;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
